// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and constants for the debounce_arbiter block.
//               - db_state_e   : arbiter FSM state encoding
//               - BTN_RELEASED : reset level of the raw-button synchronizer
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        DB_IDLE   = 2'd0,
        DB_COUNT  = 2'd1,
        DB_COMMIT = 2'd2
    } db_state_e;

    // Raw buttons are active-low, so the synchronizer comes out of reset
    // reporting "not pressed".
    localparam logic BTN_RELEASED = 1'b1;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin first-set search. Starting at
//               ptr+1 and wrapping at N_REQ, returns the index of the first
//               set bit of pend.
// Ports       : pend  [N_REQ-1:0] in  - request vector
//               ptr   [IDX_W-1:0] in  - index granted last (lowest priority)
//               idx   [IDX_W-1:0] out - selected index (0 when !valid)
//               valid             out - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // One extra bit so ptr + offset (at most 2*N_REQ-1) never overflows.
    localparam int             c_sum_w = IDX_W + 1;
    localparam logic [IDX_W:0] c_n_w   = c_sum_w'(N_REQ);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Walk offsets from farthest to nearest; the last hit written is the
    // nearest one after ptr, which gives first-set priority without a break.
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_sum  = {1'b0, ptr} + c_sum_w'(k);
            w_cand = IDX_W'((w_sum >= c_n_w) ? (w_sum - c_n_w) : w_sum);
            if (pend[w_cand]) begin
                idx   = w_cand;
                valid = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/debounce_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : debounce_arbiter
// Description : Debounces N_BUTTONS raw active-low push buttons with a single
//               shared stability counter. A round-robin scheduler grants the
//               counter to one button whose synchronized level differs from
//               its debounced state; after DEBOUNCE_CYCLES stable cycles the
//               change is committed and a one-cycle event is emitted.
// Ports       : clk            in  - system clock, rising edge
//               reset          in  - asynchronous reset, active low
//               button[N]      in  - raw buttons, active low (0 = pressed)
//               stable[N]      out - debounced level, active high
//               press_pulse[N] out - one-cycle pulse on accepted press
//               release_pulse[N] out - one-cycle pulse on accepted release
//               busy           out - counter currently granted
//               grant_id       out - index holding the counter (held in idle)
// Config      : DEBOUNCE_RELEASE_PULSE_EN - when defined, accepted releases
//               drive release_pulse; otherwise release_pulse is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_arbiter
    import debounce_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_BUTTONS-1:0]         button,
    output logic [N_BUTTONS-1:0]         stable,
    output logic [N_BUTTONS-1:0]         press_pulse,
    output logic [N_BUTTONS-1:0]         release_pulse,
    output logic                         busy,
    output logic [$clog2(N_BUTTONS)-1:0] grant_id
);

    localparam int               c_idx_w     = $clog2(N_BUTTONS);
    localparam int               c_cnt_w     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    // Pointer starts at the top index so button 0 is searched first.
    localparam logic [c_idx_w-1:0] c_ptr_rst  = c_idx_w'(N_BUTTONS - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizer on the raw inputs
    // ------------------------------------------------------------------
    logic [N_BUTTONS-1:0] sync1_q;
    logic [N_BUTTONS-1:0] sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= {N_BUTTONS{BTN_RELEASED}};
            sync2_q <= {N_BUTTONS{BTN_RELEASED}};
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    db_state_e            state_q,  state_d;
    logic [c_cnt_w-1:0]   cnt_q,    cnt_d;
    logic [c_idx_w-1:0]   ptr_q,    ptr_d;
    logic [c_idx_w-1:0]   grant_q,  grant_d;
    logic [N_BUTTONS-1:0] stable_q, stable_d;
    logic [N_BUTTONS-1:0] press_q,  press_d;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    logic [N_BUTTONS-1:0] release_q, release_d;
`endif

    logic [N_BUTTONS-1:0] w_pressed;
    logic [N_BUTTONS-1:0] w_pend;
    logic [c_idx_w-1:0]   w_pick_idx;
    logic                 w_pick_valid;

    assign w_pressed = ~sync2_q;
    // A button needs attention whenever its synchronized level disagrees
    // with the debounced view.
    assign w_pend    = w_pressed ^ stable_q;

    rr_pick #(
        .N_REQ (N_BUTTONS),
        .IDX_W (c_idx_w)
    ) u_rr_pick (
        .pend  (w_pend),
        .ptr   (ptr_q),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        stable_d = stable_q;
        press_d  = '0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        release_d = '0;
`endif
        case (state_q)
            DB_IDLE: begin
                if (w_pick_valid) begin
                    grant_d = w_pick_idx;
                    cnt_d   = '0;
                    state_d = DB_COUNT;
                end
            end

            DB_COUNT: begin
                if (!w_pend[grant_q]) begin
                    // Input bounced back: drop the grant, but still move the
                    // pointer so a chattering button cannot hog the counter.
                    state_d = DB_IDLE;
                    ptr_d   = grant_q;
                end else if (cnt_q == c_cnt_last) begin
                    // Equality is checked before incrementing, so the counter
                    // never needs a value beyond DEBOUNCE_CYCLES-1.
                    state_d           = DB_COMMIT;
                    stable_d[grant_q] = ~stable_q[grant_q];
                    if (stable_q[grant_q] == 1'b0) begin
                        press_d[grant_q] = 1'b1;
                    end
`ifdef DEBOUNCE_RELEASE_PULSE_EN
                    else begin
                        release_d[grant_q] = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DB_COMMIT: begin
                state_d = DB_IDLE;
                ptr_d   = grant_q;
            end

            default: begin
                state_d = DB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= DB_IDLE;
            cnt_q    <= '0;
            ptr_q    <= c_ptr_rst;
            grant_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            release_q <= '0;
        end else begin
            release_q <= release_d;
        end
    end

    assign release_pulse = release_q;
`else
    assign release_pulse = '0;
`endif

    assign stable      = stable_q;
    assign press_pulse = press_q;
    assign busy        = (state_q != DB_IDLE);
    assign grant_id    = grant_q;

endmodule : debounce_arbiter
`default_nettype wire

// File: tb/tb_debounce_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_arbiter
// Description : Self-checking bench for debounce_arbiter (N=4, D=8).
//               Directed latency scenarios plus randomized button activity,
//               all compared against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_arbiter;

    localparam int N = 4;
    localparam int D = 8;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic [N-1:0] button = '1;
    logic [N-1:0] stable;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic         busy;
    logic [1:0]   grant_id;

    always #5 clk = ~clk;

    debounce_arbiter #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button        (button),
        .stable        (stable),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Inputs reach the arbiter two edges after they are
    // sampled; "phase" is 0 when idle, 1..D while the owner is being timed
    // (phase p = p-th stable cycle), D+1 for the event cycle.
    // ------------------------------------------------------------------
    logic [N-1:0] m_s1, m_s2;
    logic [N-1:0] m_stable, m_press, m_rel;
    int           m_phase, m_owner, m_ptr;

    always @(posedge clk or negedge reset) begin : model
        logic [N-1:0] want;
        logic         found;
        int           c;
        if (!reset) begin
            m_s1 = '1; m_s2 = '1;
            m_stable = '0; m_press = '0; m_rel = '0;
            m_phase = 0; m_owner = 0; m_ptr = N - 1;
        end else begin
            want    = (~m_s2) ^ m_stable;
            m_press = '0;
            m_rel   = '0;
            if (m_phase == 0) begin
                if (want != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_ptr + k) % N;
                        if (!found && want[c]) begin
                            found   = 1'b1;
                            m_owner = c;
                        end
                    end
                    m_phase = 1;
                end
            end else if (m_phase <= D) begin
                if (!want[m_owner]) begin
                    m_phase = 0;
                    m_ptr   = m_owner;
                end else if (m_phase == D) begin
                    if (m_stable[m_owner]) begin
`ifdef DEBOUNCE_RELEASE_PULSE_EN
                        m_rel[m_owner] = 1'b1;
`endif
                    end else begin
                        m_press[m_owner] = 1'b1;
                    end
                    m_stable[m_owner] = ~m_stable[m_owner];
                    m_phase = D + 1;
                end else begin
                    m_phase = m_phase + 1;
                end
            end else begin
                m_phase = 0;
                m_ptr   = m_owner;
            end
            m_s2 = m_s1;
            m_s1 = button;
        end
    end

    always @(negedge clk) begin
        chk("stable",  stable,        m_stable);
        chk("press",   press_pulse,   m_press);
        chk("release", release_pulse, m_rel);
        chk("busy",    busy,          m_phase != 0);
        chk("grant",   grant_id,      m_owner);
        chk("excl",    $countones(press_pulse | release_pulse) <= 1, 1'b1);
    end

    // ------------------------------------------------------------------
    // Directed observation: cycle k is the interval after edge k, where
    // edge 0 is the edge just before the stimulus was applied.
    // ------------------------------------------------------------------
    int o_p_cyc[N], o_p_cnt[N], o_r_cyc[N], o_r_cnt[N], o_s_chg[N];
    int o_b_first, o_b_last, o_multi;

    task automatic observe(input int ncyc);
        logic [N-1:0] s0;
        s0 = stable;
        o_b_first = -1; o_b_last = -1; o_multi = 0;
        for (int b = 0; b < N; b++) begin
            o_p_cyc[b] = -1; o_p_cnt[b] = 0;
            o_r_cyc[b] = -1; o_r_cnt[b] = 0;
            o_s_chg[b] = -1;
        end
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if ($countones(press_pulse | release_pulse) > 1) o_multi++;
            if (busy) begin
                if (o_b_first < 0) o_b_first = k;
                o_b_last = k;
            end
            for (int b = 0; b < N; b++) begin
                if (press_pulse[b]) begin
                    o_p_cnt[b]++;
                    if (o_p_cyc[b] < 0) o_p_cyc[b] = k;
                end
                if (release_pulse[b]) begin
                    o_r_cnt[b]++;
                    if (o_r_cyc[b] < 0) o_r_cyc[b] = k;
                end
                if (stable[b] !== s0[b] && o_s_chg[b] < 0) o_s_chg[b] = k;
            end
        end
    endtask

    task automatic edge0();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rate;
        // Reset held with all buttons released
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        observe(20);
        chk("rst_busy_never", o_b_first, -1);
        chk("rst_pulses", o_p_cnt[0] + o_p_cnt[1] + o_p_cnt[2] + o_p_cnt[3]
                          + o_r_cnt[0] + o_r_cnt[1] + o_r_cnt[2] + o_r_cnt[3], 0);
        chk("rst_stable", stable, 4'b0000);
        chk("rst_grant", grant_id, 2'd0);

        // Simultaneous press of buttons 0 and 2 straight after reset
        edge0();
        button[0] = 1'b0; button[2] = 1'b0;
        observe(30);
        chk("sim_p0_cyc", o_p_cyc[0], 11);
        chk("sim_p2_cyc", o_p_cyc[2], 21);
        chk("sim_p0_cnt", o_p_cnt[0], 1);
        chk("sim_p2_cnt", o_p_cnt[2], 1);
        chk("sim_multi",  o_multi, 0);

        edge0();
        button = '1;
        repeat (40) @(posedge clk);

        // Clean press of button 1
        edge0();
        button[1] = 1'b0;
        observe(25);
        chk("press1_cyc",   o_p_cyc[1], 11);
        chk("press1_cnt",   o_p_cnt[1], 1);
        chk("press1_stab",  o_s_chg[1], 11);
        chk("press1_bfirst", o_b_first, 3);
        chk("press1_blast",  o_b_last, 11);
        chk("press1_level", stable[1], 1'b1);

        // Release of button 1
        edge0();
        button[1] = 1'b1;
        observe(25);
        chk("rel1_stab", o_s_chg[1], 11);
        chk("rel1_level", stable[1], 1'b0);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        chk("rel1_pulse_cyc", o_r_cyc[1], 11);
        chk("rel1_pulse_cnt", o_r_cnt[1], 1);
`else
        chk("rel1_pulse_cnt", o_r_cnt[1], 0);
`endif

        // Bounce on button 0: low for 4 cycles only
        edge0();
        button[0] = 1'b0;
        fork
            observe(20);
            begin
                repeat (4) @(posedge clk);
                #1 button[0] = 1'b1;
            end
        join
        chk("bnc_pulse", o_p_cnt[0], 0);
        chk("bnc_stable", stable[0], 1'b0);
        chk("bnc_busy_seen", o_b_first, 3);
        chk("bnc_busy_done", o_b_last <= 7, 1'b1);

        // Reset in the middle of counting button 3
        repeat (5) @(posedge clk);
        edge0();
        button[3] = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("rmid_pre_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("rmid_busy",   busy, 1'b0);
        chk("rmid_grant",  grant_id, 2'd0);
        chk("rmid_stable", stable, 4'b0000);
        chk("rmid_press",  press_pulse, 4'b0000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        observe(20);
        chk("rmid_p3_cyc", o_p_cyc[3], 11);
        chk("rmid_p3_cnt", o_p_cnt[3], 1);

        edge0();
        button = '1;
        repeat (20) @(posedge clk);

        // Randomized activity with varying bounce density
        for (int t = 0; t < 3000; t++) begin
            edge0();
            rate = (t < 1000) ? 11 : ((t < 2000) ? 3 : 30);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, rate) == 0) button[b] = ~button[b];
            end
            if (t == 1500) begin
                #2 reset = 1'b0;
                #1;
                chk("rnd_rst_busy", busy, 1'b0);
                chk("rnd_rst_stable", stable, 4'b0000);
                @(posedge clk);
                #1 reset = 1'b1;
            end
        end
        repeat (30) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_debounce_arbiter
`default_nettype wire
